// File: rtl/systolic_ctrl.sv
// Sequencer for an N x N systolic array: clears the accumulators, streams
// operand addresses, skews the PE enables, waits out the drain and signals completion.
// Optional busy-cycle counter enabled by defining SYSTOLIC_CTRL_PERF_EN.
module systolic_ctrl #(
    parameter int unsigned N    = 4,
    parameter int unsigned PIPE = 2,
    parameter int unsigned KW   = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [KW-1:0] k_len,
    output logic [KW-1:0] feed_addr,
    output logic          feed_vld,
    output logic [N-1:0]  lane_en,
    output logic          acc_clr,
    output logic          cap,
    output logic          busy,
    output logic          done,
    output logic [15:0]   perf_cycles
);

    localparam int unsigned DRAIN_LEN = 2 * N - 2 + PIPE;
    localparam int unsigned DW        = (DRAIN_LEN > 2) ? $clog2(DRAIN_LEN) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [KW-1:0]   k_reg;
    logic [KW-1:0]   k_nxt;
    logic [KW-1:0]   addr_nxt;
    logic [DW-1:0]   drain_cnt;
    logic [DW-1:0]   drain_nxt;
    logic            kill;
    logic            acc_clr_nxt;
    logic            feed_vld_nxt;
    logic            busy_nxt;
    logic            done_nxt;
    logic            cap_nxt;
    logic [N-1:0]    lane_nxt;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_nxt = state;
        k_nxt     = k_reg;
        addr_nxt  = '0;
        drain_nxt = '0;
        kill      = abort && (state != IDLE);

        case (state)
            IDLE: begin
                if (start && !abort) begin
                    if (k_len != '0) begin
                        state_nxt = CLEAR;
                        k_nxt     = k_len;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            CLEAR: state_nxt = FEED;
            FEED: begin
                // Terminal compare on k-1 keeps a full-scale k_len from wrapping the address
                if (feed_addr == k_reg - KW'(1)) begin
                    state_nxt = DRAIN;
                end else begin
                    addr_nxt = feed_addr + KW'(1);
                end
            end
            DRAIN: begin
                if (drain_cnt == DW'(DRAIN_LEN - 1)) begin
                    state_nxt = DONE;
                end else begin
                    drain_nxt = drain_cnt + DW'(1);
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        if (kill) begin
            state_nxt = IDLE;
        end

        if (state_nxt != FEED) begin
            addr_nxt = '0;
        end
        if (state_nxt != DRAIN) begin
            drain_nxt = '0;
        end

        acc_clr_nxt  = (state_nxt == CLEAR);
        feed_vld_nxt = (state_nxt == FEED);
        busy_nxt     = (state_nxt != IDLE);
        done_nxt     = (state_nxt == DONE);
        cap_nxt      = (state == DRAIN) && (state_nxt == DONE);
        lane_nxt     = kill ? '0 : N'({lane_en, feed_vld});
    end

    // Registered outputs and datapath counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_reg     <= '0;
            drain_cnt <= '0;
            feed_addr <= '0;
            feed_vld  <= 1'b0;
            lane_en   <= '0;
            acc_clr   <= 1'b0;
            cap       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            k_reg     <= k_nxt;
            drain_cnt <= drain_nxt;
            feed_addr <= addr_nxt;
            feed_vld  <= feed_vld_nxt;
            lane_en   <= lane_nxt;
            acc_clr   <= acc_clr_nxt;
            cap       <= cap_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [15:0] perf_cnt;
    logic [15:0] perf_inc;

    // First busy cycle counts as 1; saturate rather than wrap on very long jobs
    always_comb begin
        perf_inc = 16'd1;
        if (state != IDLE) begin
            perf_inc = (perf_cnt == 16'hFFFF) ? perf_cnt : perf_cnt + 16'd1;
        end
    end

    // An aborted job never reaches DONE, so perf_cycles keeps the previous result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cnt    <= '0;
            perf_cycles <= '0;
        end else begin
            if (state_nxt != IDLE) begin
                perf_cnt <= perf_inc;
            end
            if (state_nxt == DONE) begin
                perf_cycles <= perf_inc;
            end
        end
    end
`else
    assign perf_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed self-checking bench for systolic_ctrl (N=4, PIPE=2, KW=8).
module tb_systolic_ctrl;

    localparam int unsigned N    = 4;
    localparam int unsigned PIPE = 2;
    localparam int unsigned KW   = 8;
    localparam int          DRN  = 2 * N - 2 + PIPE;
`ifdef SYSTOLIC_CTRL_PERF_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [KW-1:0] k_len;
    logic [KW-1:0] feed_addr;
    logic          feed_vld;
    logic [N-1:0]  lane_en;
    logic          acc_clr;
    logic          cap;
    logic          busy;
    logic          done;
    logic [15:0]   perf_cycles;

    int pass_cnt  = 0;
    int total_cnt = 0;

    systolic_ctrl #(.N(N), .PIPE(PIPE), .KW(KW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .k_len      (k_len),
        .feed_addr  (feed_addr),
        .feed_vld   (feed_vld),
        .lane_en    (lane_en),
        .acc_clr    (acc_clr),
        .cap        (cap),
        .busy       (busy),
        .done       (done),
        .perf_cycles(perf_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected {acc_clr, feed_vld, feed_addr, lane_en, busy, done, cap} in cycle c of a job started in cycle 0
    function automatic logic [16:0] exp_job(int k, int c);
        logic          e_clr, e_vld, e_busy, e_done, e_cap;
        logic [KW-1:0] e_addr;
        logic [N-1:0]  e_lane;
        int            done_c;
        done_c = (k == 0) ? 1 : k + 2 + DRN;
        e_clr  = (k != 0) && (c == 1);
        e_vld  = (k != 0) && (c >= 2) && (c <= k + 1);
        e_addr = e_vld ? KW'(c - 2) : '0;
        for (int i = 0; i < int'(N); i++) begin
            e_lane[i] = (k != 0) && (c >= 3 + i) && (c <= k + 2 + i);
        end
        e_busy = (c >= 1) && (c <= done_c);
        e_done = (c == done_c);
        e_cap  = e_done && (k != 0);
        return {e_clr, e_vld, e_addr, e_lane, e_busy, e_done, e_cap};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        k_len = '0;
        #3;
        total_cnt++;
        if ({acc_clr, feed_vld, feed_addr, lane_en, busy, done, cap, perf_cycles} !== 33'd0) begin
            $display("FAIL reset_outputs got %h exp 0",
                     {acc_clr, feed_vld, feed_addr, lane_en, busy, done, cap, perf_cycles});
        end else begin
            pass_cnt++;
        end
        #10;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic_k3();
        logic [16:0] exp;
        start = 1'b1;
        k_len = KW'(3);
        for (int c = 1; c <= 15; c++) begin
            step();
            start = 1'b0;
            exp   = exp_job(3, c);
            total_cnt++;
            if ({acc_clr, feed_vld, feed_addr, lane_en, busy, done, cap} !== exp) begin
                $display("FAIL basic_k3 cycle %0d got %h exp %h", c,
                         {acc_clr, feed_vld, feed_addr, lane_en, busy, done, cap}, exp);
            end else begin
                pass_cnt++;
            end
        end
        total_cnt++;
        if (perf_cycles !== (PERF_EN ? 16'd13 : 16'd0)) begin
            $display("FAIL basic_k3_perf got %0d exp %0d", perf_cycles, PERF_EN ? 13 : 0);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_zero_len();
        logic [16:0] exp;
        start = 1'b1;
        k_len = '0;
        for (int c = 1; c <= 3; c++) begin
            step();
            start = 1'b0;
            exp   = exp_job(0, c);
            total_cnt++;
            if ({acc_clr, feed_vld, feed_addr, lane_en, busy, done, cap} !== exp) begin
                $display("FAIL zero_len cycle %0d got %h exp %h", c,
                         {acc_clr, feed_vld, feed_addr, lane_en, busy, done, cap}, exp);
            end else begin
                pass_cnt++;
            end
        end
        total_cnt++;
        if (perf_cycles !== (PERF_EN ? 16'd1 : 16'd0)) begin
            $display("FAIL zero_len_perf got %0d exp %0d", perf_cycles, PERF_EN ? 1 : 0);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_abort();
        int done_seen;
        done_seen = 0;
        start = 1'b1;
        k_len = KW'(3);
        for (int c = 1; c <= 3; c++) begin
            step();
            start = 1'b0;
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        total_cnt++;
        if ({busy, lane_en, feed_vld, feed_addr} !== 14'd0) begin
            $display("FAIL abort_cycle4 got busy=%b lane=%b vld=%b addr=%0d exp all 0",
                     busy, lane_en, feed_vld, feed_addr);
        end else begin
            pass_cnt++;
        end
        for (int c = 5; c <= 20; c++) begin
            step();
            if (done || cap || busy) done_seen++;
        end
        total_cnt++;
        if (done_seen !== 0) begin
            $display("FAIL abort_no_done got %0d active cycles exp 0", done_seen);
        end else begin
            pass_cnt++;
        end
        total_cnt++;
        if (perf_cycles !== (PERF_EN ? 16'd1 : 16'd0)) begin
            $display("FAIL abort_perf got %0d exp %0d", perf_cycles, PERF_EN ? 1 : 0);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_start_in_drain();
        int          dones;
        int          done_at;
        logic [16:0] exp;
        dones   = 0;
        done_at = -1;
        start   = 1'b1;
        k_len   = KW'(3);
        for (int c = 1; c <= 20; c++) begin
            step();
            start = (c == 7);
            k_len = (c == 7) ? KW'(0) : KW'(3);
            if (done) begin
                dones++;
                done_at = c;
            end
        end
        start = 1'b0;
        total_cnt++;
        if (dones !== 1 || done_at !== 13) begin
            $display("FAIL drain_start_ignored got %0d dones last at %0d exp 1 at 13", dones, done_at);
        end else begin
            pass_cnt++;
        end
        start = 1'b1;
        k_len = KW'(2);
        for (int c = 1; c <= 13; c++) begin
            step();
            start = 1'b0;
            exp   = exp_job(2, c);
            total_cnt++;
            if ({acc_clr, feed_vld, feed_addr, lane_en, busy, done, cap} !== exp) begin
                $display("FAIL restart_k2 cycle %0d got %h exp %h", c,
                         {acc_clr, feed_vld, feed_addr, lane_en, busy, done, cap}, exp);
            end else begin
                pass_cnt++;
            end
        end
        total_cnt++;
        if (perf_cycles !== (PERF_EN ? 16'd12 : 16'd0)) begin
            $display("FAIL restart_k2_perf got %0d exp %0d", perf_cycles, PERF_EN ? 12 : 0);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_async_reset_long();
        int          vld_cnt;
        int          bad;
        logic [16:0] exp;
        start = 1'b1;
        k_len = KW'(255);
        for (int c = 1; c <= 5; c++) begin
            step();
            start = 1'b0;
        end
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({acc_clr, feed_vld, feed_addr, lane_en, busy, done, cap, perf_cycles} !== 33'd0) begin
            $display("FAIL async_reset got %h exp 0",
                     {acc_clr, feed_vld, feed_addr, lane_en, busy, done, cap, perf_cycles});
        end else begin
            pass_cnt++;
        end
        #2;
        rst_n = 1'b1;
        step();
        vld_cnt = 0;
        bad     = 0;
        start   = 1'b1;
        k_len   = KW'(255);
        for (int c = 1; c <= 268; c++) begin
            step();
            start = 1'b0;
            exp   = exp_job(255, c);
            if (feed_vld) vld_cnt++;
            if ({acc_clr, feed_vld, feed_addr, lane_en, busy, done, cap} !== exp) begin
                bad++;
                if (bad <= 4) begin
                    $display("FAIL long_job cycle %0d got %h exp %h", c,
                             {acc_clr, feed_vld, feed_addr, lane_en, busy, done, cap}, exp);
                end
            end
            if (c == 256) begin
                total_cnt++;
                if (feed_addr !== KW'(254) || feed_vld !== 1'b1) begin
                    $display("FAIL long_last_addr got vld=%b addr=%0d exp vld=1 addr=254", feed_vld, feed_addr);
                end else begin
                    pass_cnt++;
                end
            end
            if (c == 265) begin
                total_cnt++;
                if (done !== 1'b1 || cap !== 1'b1) begin
                    $display("FAIL long_done got done=%b cap=%b exp 1 1", done, cap);
                end else begin
                    pass_cnt++;
                end
            end
        end
        total_cnt++;
        if (bad !== 0) begin
            $display("FAIL long_job_cycles got %0d bad cycles exp 0", bad);
        end else begin
            pass_cnt++;
        end
        total_cnt++;
        if (vld_cnt !== 255) begin
            $display("FAIL long_feed_count got %0d exp 255", vld_cnt);
        end else begin
            pass_cnt++;
        end
        total_cnt++;
        if (perf_cycles !== (PERF_EN ? 16'd265 : 16'd0)) begin
            $display("FAIL long_perf got %0d exp %0d", perf_cycles, PERF_EN ? 265 : 0);
        end else begin
            pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_basic_k3();
        test_zero_len();
        test_abort();
        test_start_in_drain();
        test_async_reset_long();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
